// File: rtl/facto_ctrl_p.sv
// facto_ctrl_p: factorial sequencer driving an external multiplier, with overflow saturation and a multiplier watchdog.
module facto_ctrl_p #(
    parameter int W       = 64,
    parameter int RW      = 2 * W,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            clear,
    input  logic [W-1:0]    operand,
    output logic            busy,
    output logic            done,
    output logic [RW-1:0]   result,
    output logic            overflow,
    output logic            fault,
    output logic            m_start,
    output logic            m_clear,
    output logic [RW-1:0]   m_multiplicand,
    output logic [W-1:0]    m_multiplier,
    input  logic            m_done,
    input  logic [RW+W-1:0] m_product
);
    localparam int WDW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, MSTART, MWAIT, DONE} state_t;
    state_t         state, state_n;
    logic [RW-1:0]  acc, acc_n;
    logic [W-1:0]   cnt, cnt_n;
    logic [WDW-1:0] wd, wd_n;
    logic           ovf_n, flt_n, mclr_n;
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        wd_n    = wd;
        ovf_n   = overflow;
        flt_n   = fault;
        mclr_n  = 1'b0;
        if (clear) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            wd_n    = '0;
            ovf_n   = 1'b0;
            flt_n   = 1'b0;
            mclr_n  = state == MSTART || state == MWAIT;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    cnt_n   = operand;
                    acc_n   = RW'(1);
                    ovf_n   = 1'b0;
                    flt_n   = 1'b0;
                    state_n = operand < W'(2) ? DONE : MSTART;
                end
                MSTART: begin
                    state_n = MWAIT;
                    wd_n    = '0;
                end
                MWAIT: if (m_done) begin
                    if (|m_product[RW+W-1:RW]) begin
                        ovf_n   = 1'b1;
                        acc_n   = '1;
                        state_n = DONE;
                    end else begin
                        acc_n   = m_product[RW-1:0];
                        cnt_n   = cnt - 1'b1;
                        state_n = cnt_n == W'(1) ? DONE : MSTART;
                    end
                end else if (wd == WDW'(TIMEOUT - 1)) begin
                    flt_n   = 1'b1;
                    mclr_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    wd_n = wd + 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    // m_start and operand outputs trail the MSTART state by one cycle so every output stays a flop
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            acc            <= '0;
            cnt            <= '0;
            wd             <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            result         <= '0;
            overflow       <= 1'b0;
            fault          <= 1'b0;
            m_start        <= 1'b0;
            m_clear        <= 1'b0;
            m_multiplicand <= '0;
            m_multiplier   <= '0;
        end else begin
            state          <= state_n;
            acc            <= acc_n;
            cnt            <= cnt_n;
            wd             <= wd_n;
            busy           <= state_n == MSTART || state_n == MWAIT;
            done           <= state_n == DONE;
            result         <= state_n == DONE ? acc_n : (clear ? '0 : result);
            overflow       <= ovf_n;
            fault          <= flt_n;
            m_start        <= state == MSTART && !clear;
            m_clear        <= mclr_n;
            m_multiplicand <= acc;
            m_multiplier   <= cnt;
        end
    end
endmodule

// File: tb/tb_facto_ctrl_p.sv
// tb_facto_ctrl_p: table-driven and sequence checks of facto_ctrl_p against a latency-3 multiplier model.
module tb_facto_ctrl_p;
    localparam int W  = 64;
    localparam int RW = 128;
    localparam int L  = 3;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, start_t = 1'b0, clear = 1'b0;
    logic [W-1:0]    operand = '0;
    logic            busy, done, overflow, fault, m_start, m_clear, m_done = 1'b0;
    logic [RW-1:0]   result, m_multiplicand;
    logic [W-1:0]    m_multiplier;
    logic [RW+W-1:0] m_product = '0;
    logic            t_busy, t_done, t_overflow, t_fault, t_m_start, t_m_clear;
    logic [RW-1:0]   t_result, t_m_multiplicand;
    logic [W-1:0]    t_m_multiplier;
    logic            t_m_done = 1'b0;
    logic [RW+W-1:0] t_m_product = '0;
    int checks = 0, errors = 0;
    int ms_cnt = 0, mc_cnt = 0, tmc_cnt = 0;
    logic [W-1:0] ms_q[$];
    logic pend = 1'b0;
    int k = 0;
    always #5 clk = ~clk;
    facto_ctrl_p #(.W(W), .RW(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear), .operand(operand),
        .busy(busy), .done(done), .result(result), .overflow(overflow), .fault(fault),
        .m_start(m_start), .m_clear(m_clear), .m_multiplicand(m_multiplicand),
        .m_multiplier(m_multiplier), .m_done(m_done), .m_product(m_product));
    facto_ctrl_p #(.W(W), .RW(RW), .TIMEOUT(8)) dut_t (
        .clk(clk), .reset(reset), .start(start_t), .clear(clear), .operand(operand),
        .busy(t_busy), .done(t_done), .result(t_result), .overflow(t_overflow), .fault(t_fault),
        .m_start(t_m_start), .m_clear(t_m_clear), .m_multiplicand(t_m_multiplicand),
        .m_multiplier(t_m_multiplier), .m_done(t_m_done), .m_product(t_m_product));
    // multiplier model: m_done is high L cycles after the cycle in which m_start was high
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (reset || m_clear) pend <= 1'b0;
        else if (m_start) begin
            pend      <= 1'b1;
            k         <= L - 1;
            m_product <= (RW+W)'(m_multiplicand) * (RW+W)'(m_multiplier);
        end else if (pend) begin
            if (k == 1) begin
                m_done <= 1'b1;
                pend   <= 1'b0;
            end else k <= k - 1;
        end
    end
    always @(negedge clk) begin
        if (m_start) begin
            ms_cnt++;
            ms_q.push_back(m_multiplier);
        end
        if (m_clear) mc_cnt++;
        if (t_m_clear) tmc_cnt++;
    end
    typedef struct {
        logic [W-1:0]  op;
        logic [RW-1:0] res;
        logic          ovf;
        int            cyc;
        int            nms;
    } vec_t;
    vec_t v[8];
    function automatic logic [255:0] fact(input int n);
        logic [255:0] f = 256'd1;
        for (int i = 2; i <= n; i++) f = f * 256'(i);
        return f;
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic launch(input logic [W-1:0] n, output int cyc);
        operand = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask
    initial begin
        logic [255:0] f34;
        int cyc, b, qb, mb, n;
        f34 = fact(34);
        v[0] = '{64'd5, 128'd120, 1'b0, 21, 4};
        v[1] = '{64'd0, 128'd1, 1'b0, 1, 0};
        v[2] = '{64'd1, 128'd1, 1'b0, 1, 0};
        v[3] = '{64'd2, 128'd2, 1'b0, 6, 1};
        v[4] = '{64'd3, 128'd6, 1'b0, 11, 2};
        v[5] = '{64'd7, 128'd5040, 1'b0, 31, 6};
        v[6] = '{64'd34, f34[RW-1:0], 1'b0, 166, 33};
        v[7] = '{64'd35, {RW{1'b1}}, 1'b1, -1, -1};
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_mstart", m_start, 0);
        chk("rst_mcand", m_multiplicand, 0);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            b = ms_cnt;
            qb = ms_q.size();
            mb = mc_cnt;
            launch(v[i].op, cyc);
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_result", i), result, v[i].res);
            chk($sformatf("v%0d_ovf", i), overflow, v[i].ovf);
            chk($sformatf("v%0d_fault", i), fault, 0);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_mclear", i), RW'(mc_cnt - mb), 0);
            if (v[i].cyc >= 0) chk($sformatf("v%0d_cycles", i), RW'(cyc), RW'(v[i].cyc));
            if (v[i].nms >= 0) chk($sformatf("v%0d_mstarts", i), RW'(ms_cnt - b), RW'(v[i].nms));
            if (v[i].op == 64'd5)
                for (int j = 0; j < 4; j++) chk($sformatf("mult_%0d", j), RW'(ms_q[qb + j]), RW'(5 - j));
        end
        // clear during the third MWAIT episode of a 10! run
        mb = mc_cnt;
        operand = 64'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 100 && n < 3; c++) begin
            tick();
            if (m_start) n++;
        end
        chk("clr_reached", RW'(n), 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_result", result, 0);
        chk("clr_mclear_hi", m_clear, 1);
        tick();
        chk("clr_mclear_lo", m_clear, 0);
        chk("clr_mclear_cnt", RW'(mc_cnt - mb), 1);
        launch(64'd4, cyc);
        chk("after_clr_result", result, 24);
        chk("after_clr_cycles", RW'(cyc), 16);
        // clear beats start
        operand = 64'd3;
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        chk("clrstart_done", done, 0);
        chk("clrstart_busy", busy, 0);
        tick();
        chk("clrstart_busy2", busy, 0);
        // watchdog with a multiplier that never answers
        b = tmc_cnt;
        operand = 64'd5;
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        cyc = 1;
        while (!t_done && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("to_done", t_done, 1);
        chk("to_cycles", RW'(cyc), 10);
        chk("to_fault", t_fault, 1);
        chk("to_mclear", t_m_clear, 1);
        tick();
        chk("to_mclear_cnt", RW'(tmc_cnt - b), 1);
        operand = 64'd0;
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        chk("to_fault_cleared", t_fault, 0);
        chk("to_relaunch_res", t_result, 1);
        // start while busy is ignored, then relaunch from DONE
        operand = 64'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        operand = 64'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        operand = 64'd0;
        cyc = 4;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("busy_start_res", result, 720);
        chk("busy_start_cycles", RW'(cyc), 26);
        launch(64'd3, cyc);
        chk("relaunch_res", result, 6);
        chk("relaunch_cycles", RW'(cyc), 11);
        // reset in MWAIT, asserted together with clear and start
        mb = mc_cnt;
        operand = 64'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        clear = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        clear = 1'b0;
        start = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_result", result, 0);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_fault", fault, 0);
        chk("mrst_mstart", m_start, 0);
        chk("mrst_mclear", m_clear, 0);
        chk("mrst_mcand", m_multiplicand, 0);
        chk("mrst_mplier", RW'(m_multiplier), 0);
        tick();
        chk("mrst_busy2", busy, 0);
        chk("mrst_mclear_cnt", RW'(mc_cnt - mb), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/facto_ctrl_p.md
FACTO_CTRL_P -- requirements
Module: facto_ctrl_p

Parameters
REQ-001 The block SHALL have parameter W, default 64, setting the operand and down-counter width in bits.
REQ-002 The block SHALL have parameter RW, default 2*W, setting the accumulator and result width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, setting the maximum cycles spent in MWAIT before a fault.

Interface
REQ-004 The block SHALL have clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 The block SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have start, input, 1 bit: launch request, sampled in IDLE and DONE.
REQ-007 The block SHALL have clear, input, 1 bit: synchronous abort/clear, sampled in every state.
REQ-008 The block SHALL have operand, input, W bits: n, captured on an accepted start.
REQ-009 The block SHALL have busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-010 The block SHALL have done, output, 1 bit: high while in DONE.
REQ-011 The block SHALL have result, output, RW bits: n! or saturated value, valid while done=1.
REQ-012 The block SHALL have overflow, output, 1 bit: n! exceeded RW bits; sticky until the next start, clear or reset.
REQ-013 The block SHALL have fault, output, 1 bit: multiplier timeout; sticky until the next start, clear or reset.
REQ-014 The block SHALL have m_start, output, 1 bit: one-cycle launch pulse to the external multiplier.
REQ-015 The block SHALL have m_clear, output, 1 bit: one-cycle clear pulse to the external multiplier.
REQ-016 The block SHALL have m_multiplicand, output, RW bits: current accumulator value.
REQ-017 The block SHALL have m_multiplier, output, W bits: current down-counter value.
REQ-018 The block SHALL have m_done, input, 1 bit: product valid; considered only in MWAIT.
REQ-019 The block SHALL have m_product, input, RW+W bits: m_multiplicand * m_multiplier.

Function
REQ-020 All outputs SHALL be registered; the state machine SHALL have the states IDLE, MSTART, MWAIT, DONE.
REQ-021 In IDLE or DONE, start=1 with clear=0 SHALL capture operand into cnt, set acc=1, and clear overflow and fault.
REQ-022 On that accepted start, operand 0 or 1 SHALL go directly to DONE with result=1 and no multiplier activity, done rising 1 cycle after start.
REQ-023 On that accepted start, operand >= 2 SHALL go to MSTART.
REQ-024 In MSTART, m_start=1 for exactly one cycle with m_multiplicand=acc and m_multiplier=cnt, then the FSM SHALL go to MWAIT and reset the watchdog to 0.
REQ-025 In MWAIT, m_done=1 with m_product[RW+W-1:RW]==0 SHALL load acc=m_product[RW-1:0] and set cnt=cnt-1.
REQ-026 After that update, if the new cnt==1 the FSM SHALL go to DONE, otherwise back to MSTART.
REQ-027 In MWAIT, m_done=1 with nonzero m_product[RW+W-1:RW] SHALL set overflow=1, set acc to all ones, and go to DONE.
REQ-028 In MWAIT, the watchdog SHALL increment each cycle without m_done.
REQ-029 On reaching TIMEOUT, the FSM SHALL set fault=1, pulse m_clear for 1 cycle, leave acc unchanged, and go to DONE.
REQ-030 In DONE, result SHALL equal acc and done=1, and the FSM SHALL hold until start or clear.
REQ-031 start SHALL be ignored while busy=1; operand changes while busy SHALL have no effect.
REQ-032 clear=1 in any state SHALL go to IDLE next cycle, zero acc, cnt, result, overflow, fault and done, and pulse m_clear once if the prior state was MSTART or MWAIT.
REQ-033 When clear and start are asserted in the same cycle, clear SHALL win.
REQ-034 When m_done and the watchdog limit occur in the same cycle, m_done SHALL win.
REQ-035 For operand n >= 2, n-1 multiplies SHALL occur; with multiplier latency L, done SHALL rise (n-1)*(L+2)+1 cycles after start, where L is the cycles from m_start to m_done.

Reset
REQ-036 reset=1 at a clk edge SHALL force IDLE and zero busy, done, result, overflow, fault, m_start, m_clear, m_multiplicand, m_multiplier, acc, cnt and the watchdog.
REQ-037 reset SHALL take priority over clear and start, and SHALL abort any operation in progress without pulsing m_clear.

Verification
REQ-038 Bench SHALL cover: defaults, L=3, operand=5, start pulse -> four m_start pulses with m_multiplier 5,4,3,2; done at cycle 21; result=120; overflow=0.
REQ-039 Bench SHALL cover: operand=0, and separately operand=1 -> result=1, done 1 cycle after start, m_start never asserted.
REQ-040 Bench SHALL cover: W=64, RW=128, operand=34 -> result=34! with overflow=0; operand=35 -> overflow=1 and result all ones.
REQ-041 Bench SHALL cover: operand=10 with clear asserted in the 3rd MWAIT -> IDLE next cycle; one m_clear pulse; result=0; a following start with operand=4 -> result=24.
REQ-042 Bench SHALL cover: m_done never asserted, TIMEOUT=8 -> fault=1 after 8 MWAIT cycles, m_clear pulse, done=1.
REQ-043 Bench SHALL cover: reset mid-MWAIT -> all outputs 0 next cycle; start during busy ignored; start in DONE re-launches.
